// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write master among NUM_REQ requesters, one transaction at a time.
// 1 cycle from grant to AWVALID; requesters are held off (req_ready low) until the owner's response returns or times out.
module axi_lite_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_strb,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [1:0]                   rsp_resp,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [ADDR_W-1:0]            AWADDR,
    output logic                         AWVALID,
    input  logic                         AWREADY,
    output logic [DATA_W-1:0]            WDATA,
    output logic [DATA_W/8-1:0]          WSTRB,
    output logic                         WVALID,
    input  logic                         WREADY,
    input  logic [1:0]                   BRESP,
    input  logic                         BVALID,
    output logic                         BREADY
);

    localparam int IDW    = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDW:0]     NREQ_W   = (IDW+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_WAIT_B    = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_last;
    logic [IDW-1:0]      r_grant;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic [1:0]          r_resp;
    logic [CNT_W-1:0]    r_cnt;

    logic [IDW-1:0]      w_winner;
    logic                w_any;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [STRB_W-1:0]   w_sel_strb;
    logic                w_aw_done;
    logic                w_w_done;
    logic                w_timeout;

    // Search starts one past the last completed owner and wraps modulo NUM_REQ.
    always_comb begin
        logic [IDW:0] w_sum;
        w_winner = '0;
        w_any    = 1'b0;
        w_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + (IDW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (!w_any && req_valid[w_sum[IDW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_strb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_sel_strb = req_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wvalid || WREADY;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready[w_winner] = 1'b1;
                    w_state_nxt         = S_ADDR_DATA;
                end
            end
            S_ADDR_DATA: begin
                if (w_aw_done && w_w_done) begin
                    w_state_nxt = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (BVALID || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_grant] = 1'b1;
                w_state_nxt        = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last    <= IDW'(NUM_REQ - 1);
            r_grant   <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_resp    <= 2'b00;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_winner;
                        r_awaddr  <= w_sel_addr;
                        r_wdata   <= w_sel_data;
                        r_wstrb   <= w_sel_strb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                S_ADDR_DATA: begin
                    if (r_awvalid && AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_WAIT_B: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A response arriving on the final count still wins over the timeout.
                    if (BVALID) begin
                        r_resp   <= BRESP;
                        r_bready <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp   <= 2'b10;
                        r_bready <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant;
    assign AWADDR   = r_awaddr;
    assign AWVALID  = r_awvalid;
    assign WDATA    = r_wdata;
    assign WSTRB    = r_wstrb;
    assign WVALID   = r_wvalid;
    assign BREADY   = r_bready;
    assign rsp_resp = r_resp;

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Bench for axi_lite_wr_arbiter: a scripted AXI slave plus a round-robin/timeout reference model
// predicts grants, payloads, per-cycle valid/ready levels and response codes.
module tb_axi_lite_wr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR*DW/8-1:0] req_strb = '0;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  rsp_valid;
    logic [1:0]     rsp_resp;
    logic           busy;
    logic [1:0]     grant_id;
    logic [AW-1:0]  AWADDR;
    logic           AWVALID;
    logic           AWREADY = 1'b0;
    logic [DW-1:0]  WDATA;
    logic [DW/8-1:0] WSTRB;
    logic           WVALID;
    logic           WREADY = 1'b0;
    logic [1:0]     BRESP = 2'b00;
    logic           BVALID = 1'b0;
    logic           BREADY;

    int checks = 0;
    int failures = 0;
    int m_last = NR - 1;
    logic [AW-1:0]   a_addr [NR];
    logic [DW-1:0]   a_data [NR];
    logic [DW/8-1:0] a_strb [NR];

    axi_lite_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
        .busy(busy), .grant_id(grant_id),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Round-robin rule: first requester after the last completed owner, wrapping.
    function automatic int rr_pick(input int last, input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++) begin
            if (m[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < NR; i++) begin
            a_addr[i] = $urandom & 32'hFFFF_FFFC;
            a_data[i] = $urandom;
            a_strb[i] = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic drive_payload();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]     = a_addr[i];
            req_data[i*DW +: DW]     = a_data[i];
            req_strb[i*DW/8 +: DW/8] = a_strb[i];
        end
    endtask

    // One full transaction with a slave that raises AWREADY/WREADY after awd/wd cycles and BVALID after bd WAIT_B cycles.
    task automatic run_txn(input logic [NR-1:0] mask, input int awd, input int wd, input int bd,
                           input logic [1:0] br, input bit late, output int won);
        int w;
        int hs;
        int k_last;
        logic [1:0] er;
        logic [NR-1:0] oh;
        drive_payload();
        req_valid = mask;
        #1;
        w = rr_pick(m_last, mask);
        won = w;
        oh = 4'b0001 << w;
        checks++; if (req_ready !== oh) begin failures++; $display("FAIL req_ready got=%b exp=%b", req_ready, oh); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        cyc();
        hs = (awd > wd) ? awd : wd;
        for (int c = 0; c <= hs; c++) begin
            if (c == 0) begin
                checks++; if (AWADDR !== a_addr[w]) begin failures++; $display("FAIL awaddr got=%h exp=%h", AWADDR, a_addr[w]); end
                checks++; if (WDATA !== a_data[w]) begin failures++; $display("FAIL wdata got=%h exp=%h", WDATA, a_data[w]); end
                checks++; if (WSTRB !== a_strb[w]) begin failures++; $display("FAIL wstrb got=%h exp=%h", WSTRB, a_strb[w]); end
                checks++; if (grant_id !== 2'(w)) begin failures++; $display("FAIL grant_id got=%0d exp=%0d", grant_id, w); end
            end
            checks++; if (AWVALID !== (c <= awd)) begin failures++; $display("FAIL awvalid c=%0d got=%b exp=%b", c, AWVALID, (c <= awd)); end
            checks++; if (WVALID !== (c <= wd)) begin failures++; $display("FAIL wvalid c=%0d got=%b exp=%b", c, WVALID, (c <= wd)); end
            checks++; if ({BREADY, req_ready, busy} !== 6'b0_0000_1) begin failures++; $display("FAIL addr_phase c=%0d got bready=%b req_ready=%b busy=%b exp 0/0000/1", c, BREADY, req_ready, busy); end
            AWREADY = (c >= awd);
            WREADY  = (c >= wd);
            cyc();
        end
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BRESP   = br;
        k_last  = (bd < TO - 1) ? bd : TO - 1;
        for (int k = 0; k <= k_last; k++) begin
            checks++; if ({BREADY, AWVALID, WVALID, rsp_valid} !== 7'b100_0000) begin failures++; $display("FAIL wait_b k=%0d got bready=%b awv=%b wv=%b rsp_valid=%b exp 1/0/0/0000", k, BREADY, AWVALID, WVALID, rsp_valid); end
            BVALID = (k >= bd);
            cyc();
        end
        er = (bd <= TO - 1) ? br : 2'b10;
        checks++; if (rsp_valid !== oh) begin failures++; $display("FAIL rsp_valid got=%b exp=%b", rsp_valid, oh); end
        checks++; if (rsp_resp !== er) begin failures++; $display("FAIL rsp_resp got=%b exp=%b", rsp_resp, er); end
        checks++; if ({BREADY, busy, req_ready} !== 6'b01_0000) begin failures++; $display("FAIL resp_phase got bready=%b busy=%b req_ready=%b exp 0/1/0000", BREADY, busy, req_ready); end
        BVALID    = late;
        req_valid = '0;
        m_last    = w;
        cyc();
        checks++; if ({rsp_valid, busy} !== 5'b0) begin failures++; $display("FAIL after_resp got rsp_valid=%b busy=%b exp 0000/0", rsp_valid, busy); end
        if (late) begin
            for (int i = 0; i < 3; i++) begin
                cyc();
                checks++; if ({rsp_valid, BREADY, busy} !== 6'b0) begin failures++; $display("FAIL late_bvalid i=%0d got rsp_valid=%b bready=%b busy=%b exp 0", i, rsp_valid, BREADY, busy); end
            end
            BVALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        #3;
        checks++; if ({AWVALID, WVALID, BREADY, busy, rsp_valid, req_ready} !== 12'b0) begin failures++; $display("FAIL reset_ctrl got awv=%b wv=%b br=%b busy=%b rv=%b rr=%b exp 0", AWVALID, WVALID, BREADY, busy, rsp_valid, req_ready); end
        checks++; if ({AWADDR, WDATA, WSTRB} !== '0) begin failures++; $display("FAIL reset_data got awaddr=%h wdata=%h wstrb=%h exp 0", AWADDR, WDATA, WSTRB); end
        checks++; if ({rsp_resp, grant_id} !== 4'b0) begin failures++; $display("FAIL reset_ids got rsp_resp=%b grant_id=%0d exp 0", rsp_resp, grant_id); end
        repeat (2) cyc();
        @(negedge clk);
        rst = 1'b1;
        m_last = NR - 1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int w;
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            run_txn(4'hF, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom), 1'b0, w);
            checks++; if (w !== exp_seq[i]) begin failures++; $display("FAIL rr_seq i=%0d got=%0d exp=%0d", i, w, exp_seq[i]); end
        end
    endtask

    task automatic test_single();
        int w;
        rand_payload();
        a_addr[1] = 32'h0000_0040;
        a_data[1] = 32'hDEAD_BEEF;
        a_strb[1] = 4'hF;
        run_txn(4'b0010, 1, 1, 1, 2'b00, 1'b0, w);
        checks++; if (w !== 1) begin failures++; $display("FAIL single_owner got=%0d exp=1", w); end
    endtask

    task automatic test_handshake_order();
        int aw_d [3] = '{3, 0, 2};
        int w_d  [3] = '{0, 3, 2};
        int w;
        logic [NR-1:0] m;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            m = 4'($urandom_range(1, 15));
            run_txn(m, aw_d[i], w_d[i], $urandom_range(0, 3), 2'($urandom), 1'b0, w);
        end
    endtask

    task automatic test_timeout();
        int w;
        rand_payload();
        run_txn(4'b0001 << $urandom_range(0, 3), 0, 0, 100, 2'b00, 1'b1, w);
        rand_payload();
        run_txn(4'($urandom_range(1, 15)), 1, 0, TO - 1, 2'b01, 1'b0, w);
        rand_payload();
        run_txn(4'($urandom_range(1, 15)), 0, 1, TO, 2'b11, 1'b1, w);
    endtask

    task automatic test_bresp();
        int w;
        rand_payload();
        run_txn(4'b0100, 0, 0, 0, 2'b11, 1'b0, w);
        checks++; if (w !== 2) begin failures++; $display("FAIL bresp_owner got=%0d exp=2", w); end
        for (int r = 0; r < 4; r++) begin
            rand_payload();
            run_txn(4'($urandom_range(1, 15)), 0, 0, $urandom_range(0, 4), 2'(r), 1'b0, w);
        end
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 25; i++) begin
            rand_payload();
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 20), 2'($urandom), 1'($urandom), w);
        end
    endtask

    task automatic test_reset_abort();
        int w;
        rand_payload();
        drive_payload();
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL abort_ready got=%b exp=1000", req_ready); end
        cyc();
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        cyc();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        cyc();
        checks++; if ({BREADY, grant_id} !== 3'b111) begin failures++; $display("FAIL abort_wait_b got bready=%b grant_id=%0d exp 1/3", BREADY, grant_id); end
        req_valid = '0;
        rst = 1'b0;
        #1;
        checks++; if ({AWVALID, WVALID, BREADY, busy, rsp_valid, req_ready, grant_id, rsp_resp} !== 16'b0) begin failures++; $display("FAIL abort_ctrl got awv=%b wv=%b br=%b busy=%b rv=%b gid=%0d resp=%b exp 0", AWVALID, WVALID, BREADY, busy, rsp_valid, grant_id, rsp_resp); end
        checks++; if ({AWADDR, WDATA, WSTRB} !== '0) begin failures++; $display("FAIL abort_data got awaddr=%h wdata=%h wstrb=%h exp 0", AWADDR, WDATA, WSTRB); end
        repeat (2) cyc();
        @(negedge clk);
        rst = 1'b1;
        m_last = NR - 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if ({rsp_valid, busy} !== 5'b0) begin failures++; $display("FAIL abort_no_rsp i=%0d got rsp_valid=%b busy=%b exp 0", i, rsp_valid, busy); end
        end
        rand_payload();
        run_txn(4'hF, 0, 0, 0, 2'b00, 1'b0, w);
        checks++; if (w !== 0) begin failures++; $display("FAIL abort_first_grant got=%0d exp=0", w); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_handshake_order();
        test_timeout();
        test_bresp();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
